// File: rtl/lcd_status_reader_if.sv
// Pin and handshake bundle for the HD44780 4-bit status reader.
// slave = the reader itself; master = the requester plus the LCD pin model.
interface lcd_status_reader_if;
  logic       readStatus;
  logic       waitReady;
  logic [3:0] LCD_DB_IN;
  logic       LCD_DB_OE;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic       active;
  logic       statusValid;
  logic       busyFlag;
  logic [6:0] address;
  logic       timedOut;

  modport slave (
    input  readStatus, waitReady, LCD_DB_IN,
    output LCD_DB_OE, LCD_RS, LCD_RW, LCD_E,
           active, statusValid, busyFlag, address, timedOut
  );

  modport master (
    output readStatus, waitReady, LCD_DB_IN,
    input  LCD_DB_OE, LCD_RS, LCD_RW, LCD_E,
           active, statusValid, busyFlag, address, timedOut
  );
endinterface

// File: rtl/lcd_status_reader.sv
// HD44780 busy-flag/address reader over the 4-bit bus: single read or poll until BF=0.
// Optional poll limit with timedOut pulse: define LCD_BUSY_TIMEOUT_EN.
module lcd_status_reader #(
  parameter int FREQ        = 50_000_000,
  parameter int T_SETUP_US  = 1,
  parameter int T_E_US      = 1,
  parameter int POLL_GAP_US = 10,
  parameter int MAX_POLLS   = 16
) (
  input logic                CLK,
  input logic                RST,
  lcd_status_reader_if.slave bus
);

  localparam int T1US = FREQ / 1_000_000;

  // Counters are loaded with length-1 so a phase lasts exactly its length in cycles.
  localparam logic [20:0] TS_M1 = 21'(T_SETUP_US * T1US - 1);
  localparam logic [20:0] TE_M1 = 21'(T_E_US * T1US - 1);
  localparam logic [20:0] TG_M1 = 21'(POLL_GAP_US * T1US - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] E1_HI = 3'd2;
  localparam logic [2:0] E1_LO = 3'd3;
  localparam logic [2:0] E2_HI = 3'd4;
  localparam logic [2:0] E2_LO = 3'd5;
  localparam logic [2:0] GAP   = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  if (T1US < 1 || T_SETUP_US < 1 || T_E_US < 1 || POLL_GAP_US < 1 ||
      MAX_POLLS < 1 || MAX_POLLS > 31) begin : g_bad_cfg
    $error("lcd_status_reader: timing parameters must be >= 1 us and MAX_POLLS in 1..31");
  end

  logic [2:0]  state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        poll_mode_q, poll_mode_d;
  logic [3:0]  hi_q, hi_d;
  logic [3:0]  lo_q, lo_d;
  logic        busy_flag_q, busy_flag_d;
  logic [6:0]  address_q, address_d;
  logic        phase_done;
  logic        keep_polling;
  logic        in_read;

`ifdef LCD_BUSY_TIMEOUT_EN
  logic [4:0] poll_cnt_q, poll_cnt_d;
  logic       limit_hit;

  // The increment for the read that is just finishing counts toward the limit.
  assign limit_hit    = (poll_cnt_q + 5'd1) >= 5'(MAX_POLLS);
  assign keep_polling = poll_mode_q && hi_q[3] && !limit_hit;
`else
  assign keep_polling = poll_mode_q && hi_q[3];
`endif

  assign phase_done = (cnt_q == 21'd0);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = phase_done ? cnt_q : cnt_q - 21'd1;
    poll_mode_d = poll_mode_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_flag_d = busy_flag_q;
    address_d   = address_q;
`ifdef LCD_BUSY_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.waitReady || bus.readStatus) begin
          poll_mode_d = bus.waitReady;
          state_d     = SETUP;
          cnt_d       = TS_M1;
`ifdef LCD_BUSY_TIMEOUT_EN
          poll_cnt_d  = 5'd0;
`endif
        end
      end
      SETUP: if (phase_done) begin
        state_d = E1_HI;
        cnt_d   = TE_M1;
      end
      E1_HI: if (phase_done) begin
        hi_d    = bus.LCD_DB_IN;
        state_d = E1_LO;
        cnt_d   = TE_M1;
      end
      E1_LO: if (phase_done) begin
        state_d = E2_HI;
        cnt_d   = TE_M1;
      end
      E2_HI: if (phase_done) begin
        lo_d    = bus.LCD_DB_IN;
        state_d = E2_LO;
        cnt_d   = TE_M1;
      end
      E2_LO: if (phase_done) begin
`ifdef LCD_BUSY_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q + 5'd1;
`endif
        if (keep_polling) begin
          state_d = GAP;
          cnt_d   = TG_M1;
        end else begin
          // Result registers load on entry so they are already valid during DONE.
          state_d     = DONE;
          busy_flag_d = hi_q[3];
          address_d   = {hi_q[2:0], lo_q};
        end
      end
      GAP: if (phase_done) begin
        state_d = SETUP;
        cnt_d   = TS_M1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      poll_mode_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_flag_q <= 1'b1;
      address_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_mode_q <= poll_mode_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_flag_q <= busy_flag_d;
      address_q   <= address_d;
    end
  end

`ifdef LCD_BUSY_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) poll_cnt_q <= '0;
    else     poll_cnt_q <= poll_cnt_d;
  end
`endif

  // Pin controls decode straight from state so reset releases the bus in the same cycle.
  assign in_read = (state_q == SETUP) || (state_q == E1_HI) || (state_q == E1_LO) ||
                   (state_q == E2_HI) || (state_q == E2_LO);

  assign bus.LCD_E       = (state_q == E1_HI) || (state_q == E2_HI);
  assign bus.LCD_RW      = in_read;
  assign bus.LCD_DB_OE   = !in_read;
  assign bus.LCD_RS      = 1'b0;
  assign bus.active      = (state_q != IDLE);
  assign bus.statusValid = (state_q == DONE);
  assign bus.busyFlag    = busy_flag_q;
  assign bus.address     = address_q;

`ifdef LCD_BUSY_TIMEOUT_EN
  // Poll mode only reaches DONE with BF=1 when the limit stopped it.
  assign bus.timedOut = (state_q == DONE) && poll_mode_q && busy_flag_q;
`else
  assign bus.timedOut = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader: LCD pin model feeds nibbles on each E rise,
// a scoreboard queue holds the expected status for every statusValid pulse.
module tb_lcd_status_reader;

`ifdef LCD_BUSY_TIMEOUT_EN
  localparam int MP = 4;
`else
  localparam int MP = 16;
`endif

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  lcd_status_reader_if bus ();

  lcd_status_reader #(.MAX_POLLS(MP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic       bf;
    logic [6:0] addr;
    logic       to;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] nib_q[$];
  logic [3:0] db_default;

  int n_checks = 0;
  int n_fail   = 0;
  int e_pulses = 0, sv_count = 0, to_count = 0, pin_viol = 0;
  int e_run = 0, e_min = 0, e_max = 0;
  int g_run = 0, g_count = 0, g_min = 0, g_max = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // LCD model and scoreboard consumer, sampled on the falling edge.
  initial begin
    logic e_prev;
    exp_t e;
    e_prev = 1'b0;
    bus.LCD_DB_IN = 4'h0;
    forever begin
      @(negedge CLK);
      if (bus.LCD_E && !e_prev) begin
        e_pulses++;
        bus.LCD_DB_IN = (nib_q.size() > 0) ? nib_q.pop_front() : db_default;
      end
      if (bus.LCD_E) e_run++;
      else if (e_run != 0) begin
        if (e_run < e_min) e_min = e_run;
        if (e_run > e_max) e_max = e_run;
        e_run = 0;
      end
      if (bus.LCD_E && (bus.LCD_DB_OE || !bus.LCD_RW)) pin_viol++;
      if (bus.active && !bus.LCD_RW) g_run++;
      else begin
        if (bus.LCD_RW && g_run != 0) begin
          g_count++;
          if (g_run < g_min) g_min = g_run;
          if (g_run > g_max) g_max = g_run;
        end
        g_run = 0;
      end
      e_prev = bus.LCD_E;
      if (bus.timedOut && !bus.statusValid) check("timedout_without_valid", 1, 0);
      if (bus.statusValid) begin
        sv_count++;
        if (bus.timedOut) to_count++;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_busyFlag", bus.busyFlag, e.bf);
          check("sb_address", bus.address, e.addr);
          check("sb_timedOut", bus.timedOut, e.to);
        end
      end
    end
  end

  task automatic clear_stats();
    e_min = 1_000_000; e_max = 0;
    g_count = 0; g_min = 1_000_000; g_max = 0;
  endtask

  task automatic pulse(input logic rs, input logic wr);
    @(negedge CLK);
    bus.readStatus = rs;
    bus.waitReady  = wr;
    @(negedge CLK);
    bus.readStatus = 1'b0;
    bus.waitReady  = 1'b0;
  endtask

  task automatic wait_sv(input int start, input int budget, input string tag);
    int n = 0;
    while (sv_count == start && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, sv_count != start, 1);
  endtask

  task automatic wait_e(input int target, input int budget, input string tag);
    int n = 0;
    while (e_pulses < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, e_pulses >= target, 1);
  endtask

  initial begin
    int base_e, base_sv, base_to, n;
    int rw_first, rw_last, oe_bad, sv_cyc;

    RST = 1'b1;
    bus.readStatus = 1'b0;
    bus.waitReady  = 1'b0;
    db_default     = 4'h0;
    clear_stats();
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_E", bus.LCD_E, 0);
    check("rst_RW", bus.LCD_RW, 0);
    check("rst_RS", bus.LCD_RS, 0);
    check("rst_DB_OE", bus.LCD_DB_OE, 1);
    check("rst_active", bus.active, 0);
    check("rst_statusValid", bus.statusValid, 0);
    check("rst_timedOut", bus.timedOut, 0);
    check("rst_busyFlag", bus.busyFlag, 1);
    check("rst_address", bus.address, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Reset during E2_HI: pins released at once, no result
    nib_q.push_back(4'h8); nib_q.push_back(4'h5);
    base_e = e_pulses;
    pulse(1'b1, 1'b0);
    wait_e(base_e + 2, 400, "mid_reach_e2");
    repeat (5) @(negedge CLK);
    check("mid_in_e2_hi", bus.LCD_E, 1);
    RST = 1'b1;
    #1;
    check("mid_E", bus.LCD_E, 0);
    check("mid_RW", bus.LCD_RW, 0);
    check("mid_DB_OE", bus.LCD_DB_OE, 1);
    check("mid_active", bus.active, 0);
    check("mid_busyFlag", bus.busyFlag, 1);
    check("mid_address", bus.address, 0);
    base_sv = sv_count;
    @(negedge CLK);
    RST = 1'b0;
    nib_q.delete();
    repeat (300) @(negedge CLK);
    check("mid_no_valid", sv_count - base_sv, 0);

    // Single read, cycle-accurate: request sampled at end of cycle 0
    clear_stats();
    nib_q.push_back(4'h8); nib_q.push_back(4'h5);
    exp_q.push_back('{bf: 1'b1, addr: 7'h05, to: 1'b0});
    base_e = e_pulses;
    rw_first = -1; rw_last = -1; oe_bad = 0; sv_cyc = -1;
    pulse(1'b1, 1'b0);
    for (int c = 1; c <= 260; c++) begin
      if (bus.LCD_RW) begin
        if (rw_first < 0) rw_first = c;
        rw_last = c;
      end
      if (bus.LCD_RW == bus.LCD_DB_OE) oe_bad++;
      if (bus.statusValid && sv_cyc < 0) sv_cyc = c;
      @(negedge CLK);
    end
    check("single_rw_first", rw_first, 1);
    check("single_rw_last", rw_last, 250);
    check("single_oe_vs_rw", oe_bad, 0);
    check("single_valid_cycle", sv_cyc, 251);
    check("single_e_pulses", e_pulses - base_e, 2);
    check("single_e_min", e_min, 50);
    check("single_e_max", e_max, 50);

    // Poll: BF=1 for three reads, then 0x3A
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      nib_q.push_back(4'h8); nib_q.push_back(4'h0);
    end
    nib_q.push_back(4'h3); nib_q.push_back(4'hA);
    exp_q.push_back('{bf: 1'b0, addr: 7'h3A, to: 1'b0});
    base_e = e_pulses; base_sv = sv_count;
    pulse(1'b0, 1'b1);
    wait_sv(base_sv, 4000, "poll_valid_seen");
    repeat (5) @(negedge CLK);
    check("poll_e_pulses", e_pulses - base_e, 8);
    check("poll_valid_count", sv_count - base_sv, 1);
    check("poll_gap_count", g_count, 3);
    check("poll_gap_min", g_min, 500);
    check("poll_gap_max", g_max, 500);
    check("poll_e_min", e_min, 50);
    check("poll_e_max", e_max, 50);

    // Requests during E1_LO are ignored
    nib_q.push_back(4'h8); nib_q.push_back(4'h1);
    exp_q.push_back('{bf: 1'b1, addr: 7'h01, to: 1'b0});
    base_e = e_pulses; base_sv = sv_count;
    pulse(1'b1, 1'b0);
    wait_e(base_e + 1, 200, "busy_req_e1");
    n = 0;
    while (bus.LCD_E && n < 100) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) @(negedge CLK);
    check("busy_req_in_e1_lo", {bus.active, bus.LCD_E, bus.LCD_RW}, 3'b101);
    pulse(1'b1, 1'b1);
    wait_sv(base_sv, 400, "busy_req_valid_seen");
    repeat (600) @(negedge CLK);
    check("busy_req_e_pulses", e_pulses - base_e, 2);
    check("busy_req_valid_count", sv_count - base_sv, 1);

    // Simultaneous requests: waitReady wins
    nib_q.push_back(4'h8); nib_q.push_back(4'h0);
    nib_q.push_back(4'h2); nib_q.push_back(4'h7);
    exp_q.push_back('{bf: 1'b0, addr: 7'h27, to: 1'b0});
    base_e = e_pulses; base_sv = sv_count;
    pulse(1'b1, 1'b1);
    wait_sv(base_sv, 1500, "simul_valid_seen");
    repeat (5) @(negedge CLK);
    check("simul_e_pulses", e_pulses - base_e, 4);
    check("simul_valid_count", sv_count - base_sv, 1);

    // BF stuck at 1
    db_default = 4'h8;
    base_e = e_pulses; base_sv = sv_count; base_to = to_count;
`ifdef LCD_BUSY_TIMEOUT_EN
    exp_q.push_back('{bf: 1'b1, addr: 7'h08, to: 1'b1});
    pulse(1'b0, 1'b1);
    wait_sv(base_sv, 3000, "timeout_valid_seen");
    repeat (5) @(negedge CLK);
    check("timeout_e_pulses", e_pulses - base_e, 8);
    check("timeout_pulse_count", to_count - base_to, 1);
`else
    pulse(1'b0, 1'b1);
    wait_e(base_e + 12, 5000, "nolimit_six_reads");
    check("nolimit_still_active", bus.active, 1);
    check("nolimit_no_valid", sv_count - base_sv, 0);
    check("nolimit_no_timeout", to_count - base_to, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
`endif
    repeat (5) @(negedge CLK);

    check("scoreboard_empty", exp_q.size(), 0);
    check("e_with_pins_driven", pin_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Reads the HD44780 busy flag and address counter over the 4-bit bus (RS=0, RW=1), the read-direction counterpart of the existing 4-bit command/text writer.
- Runs a single status read on request, or polls until BF=0 so the writer can replace fixed worst-case delays with ready checks.
- Sits beside the writer; the top level muxes LCD_E/RS and the DB pin drivers using `active`.

Parameters:
FREQ, 50000000, system clock in Hz; T1US = FREQ/1000000 cycles (50 at default)
T_SETUP_US, 1, RW/RS setup time before E rises, in us
T_E_US, 1, E high width and E low width, each in us
POLL_GAP_US, 10, idle gap between successive reads while polling, in us
MAX_POLLS, 16, poll read limit (used only with the optional feature)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
readStatus  in  1  one-cycle request: one status read
waitReady  in  1  one-cycle request: poll until BF=0
LCD_DB_IN  in  4  D7..D4 pin inputs
LCD_DB_OE  out  1  1 = the FPGA drives D7..D4; 0 = the pins are released
LCD_RS  out  1  register select, always 0 for this block
LCD_RW  out  1  1 = read
LCD_E  out  1  enable strobe
active  out  1  high whenever the FSM is not in IDLE
statusValid  out  1  one-cycle pulse when the result is updated
busyFlag  out  1  last BF read
address  out  7  last address counter read
timedOut  out  1  one-cycle pulse with statusValid when the poll limit is hit

Behaviour:
- Reset state (asynchronous, any state): FSM in IDLE, LCD_E=0, LCD_RW=0, LCD_RS=0, LCD_DB_OE=1, active=0, statusValid=0, timedOut=0, busyFlag=1, address=0, all counters 0.
- Phase lengths: TS = T_SETUP_US*T1US, TE = T_E_US*T1US, TG = POLL_GAP_US*T1US. Each uses a 21-bit down-counter.
- FSM states: IDLE, SETUP, E1_HI, E1_LO, E2_HI, E2_LO, GAP, DONE.
- IDLE:
  - A request is accepted only here. In the same cycle, waitReady has priority over readStatus.
  - The accepted request latches the mode (single or poll).
  - Requests that arrive in any other state are ignored.
- SETUP (TS cycles): RW=1, DB_OE=0, E=0.
- E1_HI (TE cycles): E=1. On the last cycle, sample LCD_DB_IN into hi[3:0].
- E1_LO (TE cycles): E=0.
- E2_HI (TE cycles): E=1. On the last cycle, sample LCD_DB_IN into lo[3:0].
- E2_LO (TE cycles): E=0; RW stays 1 and DB_OE stays 0 (hold time).
- After E2_LO:
  - Single mode, or poll mode with hi[3]=0: go to DONE.
  - Poll mode with hi[3]=1: go to GAP.
- GAP (TG cycles): RW=0, DB_OE=1, E=0. Then go to SETUP and run another read.
- DONE (1 cycle):
  - busyFlag <= hi[3]; address <= {hi[2:0], lo}; statusValid=1.
  - RW=0, DB_OE=1. Next state is IDLE.
- Single-read latency: request in cycle N gives statusValid in cycle N+1+TS+4*TE, which is N+251 at defaults.
- LCD_RW is high exactly while E can be high, plus the setup and hold phases. E never rises while DB_OE=1.
- active=1 in every state except IDLE, including DONE.
- busyFlag and address change only in DONE and on reset.
- Reset mid-transaction: E drops immediately and the pins are released back to the FPGA (DB_OE=1). No statusValid pulse is produced.

Optional Feature:
- Macro: LCD_BUSY_TIMEOUT_EN.
- Defined:
  - A 5-bit poll counter is cleared on request acceptance and incremented at each E2_LO exit.
  - If a read completes with BF=1 and the counter reaches MAX_POLLS, go to DONE instead of GAP.
  - In that DONE cycle, timedOut=1 and statusValid=1, with busyFlag=1.
- Not defined:
  - Polling continues indefinitely while BF=1.
  - timedOut is tied to 0, and the poll counter is not synthesised.

Test Plan:
- Single read: readStatus at cycle 0, bench drives DB=0x8 during E1_HI and 0x5 during E2_HI. Required: exactly 2 E pulses, each 50 cycles high. statusValid at cycle 251 with busyFlag=1 and address=0x05. RW=1 from cycle 1 through 250, DB_OE=0 over the same span.
- Poll: waitReady, with BF=1 for the first 3 reads and 0 on the 4th (low nibble 0xA, high nibble 0x3). Required: 8 E pulses and a 500-cycle gap with RW=0 between reads. statusValid once, busyFlag=0, address=0x3A.
- Requests while active: readStatus and waitReady pulsed during E1_LO. Required: no effect; the transaction completes as a single read.
- Simultaneous request: readStatus and waitReady in the same cycle with BF=1 then 0. Required: poll behaviour, i.e. 2 reads.
- Reset mid-operation: RST asserted during E2_HI. Required: same cycle E=0, RW=0, DB_OE=1, active=0. busyFlag and address unchanged from their reset values, and no statusValid pulse.
- Timeout (LCD_BUSY_TIMEOUT_EN, MAX_POLLS=4): BF held at 1. Required: exactly 4 reads, then statusValid and timedOut pulse in the same cycle with busyFlag=1. Without the macro, reads continue past 4.
